pwl_act_unit: RTL and testbench



---
 rtl/pwl_act_unit.sv | 173 +++++++++++++++++
 tb/tb_pwl_act_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_unit.sv
// Piecewise-linear activation unit: runtime-loadable sigmoid/tanh segment
// coefficient banks around a 3-stage select / multiply-add / symmetry pipeline.
module pwl_act_unit #(
    parameter int unsigned NUM_SEGMENTS = 16,
    parameter int unsigned ADDR_WL      = $clog2(NUM_SEGMENTS),
    parameter int unsigned X_WI         = 4,
    parameter int unsigned X_WF         = 8,
    parameter int unsigned A_WI         = 1,
    parameter int unsigned A_WF         = 7,
    parameter int unsigned B_WI         = 1,
    parameter int unsigned B_WF         = 7,
    parameter int unsigned Y_WF         = 7
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               in_valid,
    input  logic                               in_mode,
    input  logic [X_WI+X_WF-1:0]               in_x,
    input  logic                               wr_en,
    input  logic                               wr_func,
    input  logic [ADDR_WL-1:0]                 wr_addr,
    input  logic [A_WI+A_WF+B_WI+B_WF-1:0]     wr_data,
    output logic                               out_valid,
    output logic [Y_WF+1:0]                    out_y,
    output logic                               cfg_err
);

    localparam int unsigned X_WL    = X_WI + X_WF;
    localparam int unsigned MAG_WL  = X_WL - 1;
    localparam int unsigned A_WL    = A_WI + A_WF;
    localparam int unsigned B_WL    = B_WI + B_WF;
    localparam int unsigned C_WL    = A_WL + B_WL;
    localparam int unsigned Y_WL    = Y_WF + 2;
    localparam int unsigned DEPTH   = NUM_SEGMENTS - 1;
    localparam int unsigned PROD_WL = A_WL + MAG_WL + 1;
    localparam int unsigned SUM_WL  = PROD_WL + 1;
    localparam int unsigned P_FRAC  = X_WF + A_WF;
    localparam int unsigned B_SHIFT = P_FRAC - B_WF;
    localparam int unsigned R_SHIFT = P_FRAC - Y_WF;

    localparam logic signed [SUM_WL-1:0] HALF  = SUM_WL'(1) << (R_SHIFT - 1);
    localparam logic signed [SUM_WL-1:0] ONE_S = SUM_WL'(1) << Y_WF;
    localparam logic [Y_WL-1:0]          ONE_Y = Y_WL'(1) << Y_WF;

    // coefficient banks: [0] sigmoid, [1] tanh
    logic [C_WL-1:0] tbl [2][DEPTH];

    // stage 1 registers
    logic                s1_valid, s1_mode, s1_sign;
    logic [MAG_WL-1:0]   s1_mag;
    logic [ADDR_WL-1:0]  s1_idx;

    // stage 2 registers
    logic                      s2_valid, s2_mode, s2_sign, s2_sat;
    logic signed [PROD_WL-1:0] s2_prod;
    logic signed [B_WL-1:0]    s2_b;

    // stage 1 combinational: sign/magnitude split with most-negative saturation
    logic              sign_c;
    logic [X_WL-1:0]   neg_c;
    logic [MAG_WL-1:0] mag_c;

    // stage 2 combinational: coefficient read and slope product
    logic [C_WL-1:0]           coef_c;
    logic signed [A_WL-1:0]    a_c;
    logic signed [PROD_WL-1:0] a_ext_c, m_ext_c, prod_c;
    logic                      sat_c;

    // stage 3 combinational: offset add, rounding, clamp, symmetry
    logic signed [SUM_WL-1:0] b_ext_c, sum_c, rsum_c, p_s_c;
    logic [Y_WL-1:0]          p_c, y_c;

    // absolute value of the input; -2^(X_WL-1) has no positive twin, so clip it
    always_comb begin
        sign_c = in_x[X_WL-1];
        neg_c  = -in_x;
        mag_c  = in_x[MAG_WL-1:0];
        if (sign_c) begin
            if (neg_c[X_WL-1]) mag_c = '1;
            else               mag_c = neg_c[MAG_WL-1:0];
        end
    end

    // segment lookup and A*|x|; last segment skips the table and saturates
    always_comb begin
        sat_c  = (s1_idx >= ADDR_WL'(DEPTH));
        coef_c = '0;
        if (!sat_c) coef_c = tbl[s1_mode][s1_idx];
        a_c     = coef_c[C_WL-1:B_WL];
        a_ext_c = PROD_WL'(a_c);
        m_ext_c = PROD_WL'({1'b0, s1_mag});
        prod_c  = a_ext_c * m_ext_c;
    end

    // align B to the product scale, round half-up, clamp to [0,1], mirror negatives
    always_comb begin
        b_ext_c = SUM_WL'(s2_b);
        sum_c   = SUM_WL'(s2_prod) + (b_ext_c <<< B_SHIFT);
        rsum_c  = sum_c + HALF;
        p_s_c   = rsum_c >>> R_SHIFT;
        if (p_s_c < 0)          p_c = '0;
        else if (p_s_c > ONE_S) p_c = ONE_Y;
        else                    p_c = Y_WL'(p_s_c);
        if (s2_sat) p_c = ONE_Y;
        y_c = p_c;
        if (s2_sign) y_c = s2_mode ? -p_c : (ONE_Y - p_c);
    end

    // coefficient table writes; reads in stage 2 see pre-edge contents
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int f = 0; f < 2; f++)
                for (int i = 0; i < int'(DEPTH); i++)
                    tbl[f][i] <= '0;
        end else if (wr_en && (wr_addr < ADDR_WL'(DEPTH))) begin
            tbl[wr_func][wr_addr] <= wr_data;
        end
    end

    // sticky flag for writes aimed at the saturation segment
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                     cfg_err <= 1'b0;
        else if (wr_en && (wr_addr >= ADDR_WL'(DEPTH))) cfg_err <= 1'b1;
    end

    // stage 1 register: sample capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_sign  <= sign_c;
            s1_mag   <= mag_c;
            s1_idx   <= mag_c[MAG_WL-1 -: ADDR_WL];
        end
    end

    // stage 2 register: product, offset and saturation flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_prod  <= '0;
            s2_b     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_sign  <= s1_sign;
            s2_sat   <= sat_c;
            s2_prod  <= prod_c;
            s2_b     <= coef_c[B_WL-1:0];
        end
    end

    // output register: result updates only for valid samples, otherwise holds
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) out_y <= y_c;
        end
    end

endmodule

// File: tb/tb_pwl_act_unit.sv
// Testbench for pwl_act_unit: directed scenarios plus randomized traffic
// checked against an arithmetic model of the activation rules.
module tb_pwl_act_unit;

    localparam int USE_MODEL = 99999;

    logic        CLK, RST_N;
    logic        in_valid, in_mode;
    logic [11:0] in_x;
    logic        wr_en, wr_func;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        out_valid;
    logic [8:0]  out_y;
    logic        cfg_err;

    int n_total = 0;
    int n_bad   = 0;

    // model state: coefficient banks, expected-result delay line, held output
    int ma [2][15];
    int mb [2][15];
    bit exp_cfg;
    bit ev [3];
    int ey [3];
    int last_y;

    pwl_act_unit dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_mode(in_mode), .in_x(in_x),
        .wr_en(wr_en), .wr_func(wr_func), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_y(out_y), .cfg_err(cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // activation from the rules: segment of |x| is |x|/0.5, A*|x|+B, round, clamp, mirror
    function automatic int model(input bit m, input logic [11:0] x);
        int xi, mag, seg, sum, p;
        bit neg;
        xi  = int'($signed(x));
        neg = (xi < 0);
        mag = neg ? -xi : xi;
        if (mag > 2047) mag = 2047;
        seg = mag / 128;
        if (seg >= 15) p = 128;
        else begin
            sum = ma[m][seg] * mag + mb[m][seg] * 256;
            p   = (sum + 128) >>> 8;
            if (p < 0)   p = 0;
            if (p > 128) p = 128;
        end
        if (!neg) return p;
        return m ? -p : 128 - p;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 15; i++) begin
                ma[f][i] = 0;
                mb[f][i] = 0;
            end
        exp_cfg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            ey[i] = 0;
        end
        last_y = 0;
    endtask

    // drive one cycle of inputs, advance the model, return at posedge+1
    task automatic step(input bit v, input bit m, input logic [11:0] x, input int exp_y,
                        input bit we, input bit wf, input logic [3:0] wa, input logic [15:0] wd);
        logic signed [7:0] t;
        int e;
        in_valid = v; in_mode = m; in_x = x;
        wr_en = we; wr_func = wf; wr_addr = wa; wr_data = wd;
        if (we) begin
            if (wa == 4'd15) exp_cfg = 1'b1;
            else begin
                t = wd[15:8]; ma[wf][wa] = int'(t);
                t = wd[7:0];  mb[wf][wa] = int'(t);
            end
        end
        e = (exp_y == USE_MODEL) ? model(m, x) : exp_y;
        ev[2] = ev[1]; ey[2] = ey[1];
        ev[1] = ev[0]; ey[1] = ey[0];
        ev[0] = v;     ey[0] = e;
        @(posedge CLK);
        #1;
        if (ev[2]) last_y = ey[2];
        in_valid = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 12'h000, 0, 1'b0, 1'b0, 4'd0, 16'h0000);
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        model_reset();
        #20;
        n_total++;
        if (out_valid !== 1'b0 || out_y !== 9'd0 || cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: valid=%0b y=%0d cfg_err=%0b required 0 0 0", out_valid, out_y, cfg_err);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_sigmoid();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0, 4'd0, 16'h2040);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 12'h000, 64, 1'b0, 1'b0, 4'd0, 16'h0);
                1: step(1'b1, 1'b0, 12'h040, 72, 1'b0, 1'b0, 4'd0, 16'h0);
                2: step(1'b1, 1'b0, 12'hFC0, 56, 1'b0, 1'b0, 4'd0, 16'h0);
                default: idle();
            endcase
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y)) begin
                n_bad++;
                $display("FAIL sigmoid cyc%0d: valid=%0b y=%0d required valid=%0b y=%0d",
                         i, out_valid, $signed(out_y), ev[2], last_y);
            end
        end
    endtask

    task automatic test_tanh_interleave();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b1, 4'd0, 16'h7F00);
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 12'h040,  72, 1'b0, 1'b0, 4'd0, 16'h0);
                1: step(1'b1, 1'b1, 12'h040,  32, 1'b0, 1'b0, 4'd0, 16'h0);
                2: step(1'b1, 1'b0, 12'hFC0,  56, 1'b0, 1'b0, 4'd0, 16'h0);
                3: step(1'b1, 1'b1, 12'hFC0, -32, 1'b0, 1'b0, 4'd0, 16'h0);
                4: step(1'b1, 1'b0, 12'h000,  64, 1'b0, 1'b0, 4'd0, 16'h0);
                5: step(1'b1, 1'b1, 12'h000,   0, 1'b0, 1'b0, 4'd0, 16'h0);
                default: idle();
            endcase
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y)) begin
                n_bad++;
                $display("FAIL tanh_interleave cyc%0d: valid=%0b y=%0d required valid=%0b y=%0d",
                         i, out_valid, $signed(out_y), ev[2], last_y);
            end
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0, 4'd14, 16'($urandom));
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b1, 4'd14, 16'($urandom));
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 12'h780,  128, 1'b0, 1'b0, 4'd0, 16'h0);
                1: step(1'b1, 1'b1, 12'h780,  128, 1'b0, 1'b0, 4'd0, 16'h0);
                2: step(1'b1, 1'b0, 12'h800,    0, 1'b0, 1'b0, 4'd0, 16'h0);
                3: step(1'b1, 1'b1, 12'h800, -128, 1'b0, 1'b0, 4'd0, 16'h0);
                default: idle();
            endcase
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y)) begin
                n_bad++;
                $display("FAIL saturation cyc%0d: valid=%0b y=%0d required valid=%0b y=%0d",
                         i, out_valid, $signed(out_y), ev[2], last_y);
            end
        end
    endtask

    task automatic test_illegal_write();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0, 4'd15, 16'hFFFF);
        n_total++;
        if (cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_write_flag: cfg_err=%0b required 1", cfg_err);
        end
        // probe one positive sample per table segment; entries must be untouched
        for (int i = 0; i < 18; i++) begin
            if (i < 15) step(1'b1, 1'b0, 12'(i * 128 + 37), USE_MODEL, 1'b0, 1'b0, 4'd0, 16'h0);
            else        idle();
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y) || cfg_err !== exp_cfg) begin
                n_bad++;
                $display("FAIL illegal_write cyc%0d: valid=%0b y=%0d cfg_err=%0b required valid=%0b y=%0d cfg_err=%0b",
                         i, out_valid, $signed(out_y), cfg_err, ev[2], last_y, exp_cfg);
            end
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0, 4'd0, 16'h2040);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 12'h000, 64, 1'b0, 1'b0, 4'd0, 16'h0);
                1: step(1'b1, 1'b0, 12'h000, 32, 1'b1, 1'b0, 4'd0, 16'h0020);
                default: idle();
            endcase
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y)) begin
                n_bad++;
                $display("FAIL collision cyc%0d: valid=%0b y=%0d required valid=%0b y=%0d",
                         i, out_valid, $signed(out_y), ev[2], last_y);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 303; i++) begin
            if (i < 300)
                step(($urandom % 4) != 0, 1'($urandom), 12'($urandom), USE_MODEL,
                     ($urandom % 3) == 0, 1'($urandom), 4'($urandom_range(0, 14)), 16'($urandom));
            else
                idle();
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y) || cfg_err !== exp_cfg) begin
                n_bad++;
                $display("FAIL random cyc%0d: valid=%0b y=%0d cfg_err=%0b required valid=%0b y=%0d cfg_err=%0b",
                         i, out_valid, $signed(out_y), cfg_err, ev[2], last_y, exp_cfg);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0, 4'd0, 16'h2040);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 12'h040, 72, 1'b0, 1'b0, 4'd0, 16'h0);
        n_total++;
        if (out_valid !== 1'b1 || out_y !== 9'd72) begin
            n_bad++;
            $display("FAIL pre_reset: valid=%0b y=%0d required 1 72", out_valid, $signed(out_y));
        end
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_y !== 9'd0 || cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%0b y=%0d cfg_err=%0b required 0 0 0", out_valid, out_y, cfg_err);
        end
        model_reset();
        #4 RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 12'h000,   0, 1'b0, 1'b0, 4'd0, 16'h0);
                1: step(1'b1, 1'b0, 12'hFC0, 128, 1'b0, 1'b0, 4'd0, 16'h0);
                2: step(1'b1, 1'b1, 12'h040,   0, 1'b0, 1'b0, 4'd0, 16'h0);
                default: idle();
            endcase
            n_total++;
            if (out_valid !== ev[2] || out_y !== 9'(last_y)) begin
                n_bad++;
                $display("FAIL post_reset cyc%0d: valid=%0b y=%0d required valid=%0b y=%0d",
                         i, out_valid, $signed(out_y), ev[2], last_y);
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_mode = 1'b0; in_x = '0;
        wr_en = 1'b0; wr_func = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_sigmoid();
        test_tanh_interleave();
        test_saturation();
        test_illegal_write();
        test_collision();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
